// File: rtl/full_adder_pkg.sv
// Shared constants and a behavioural reference for the registered adder.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // Packed result {ovf, c_out, s}; s is the low FA_MAX_WIDTH bits.
  // Width w selects the active operand size (1..64).
  function automatic logic [FA_MAX_WIDTH+1:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    c_in,
    input int unsigned             w = 1
  );
    logic [FA_MAX_WIDTH-1:0] mask;
    logic [FA_MAX_WIDTH-1:0] am;
    logic [FA_MAX_WIDTH-1:0] bm;
    logic [FA_MAX_WIDTH:0]   full;
    logic [FA_MAX_WIDTH-1:0] s;
    logic                    co;
    logic                    ov;
    mask = (w >= FA_MAX_WIDTH) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    full = {1'b0, am} + {1'b0, bm} + {{FA_MAX_WIDTH{1'b0}}, c_in};
    s    = full[FA_MAX_WIDTH-1:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// Combinational 1-bit full adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder built from fa_cell leaves.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (w_c[i]),
      .s     (w_s[i]),
      .c_out (w_c[i+1])
    );
  end

  // For WIDTH=1 the carry into the MSB is c_in itself.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;
  logic             r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s     <= w_s;
        r_c_out <= w_c[WIDTH];
        r_ovf   <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at widths 1, 8 and 16.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic        ov1, s1, co1, of1;
  logic        v8 = 1'b0, c8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        ov8, co8, of8;
  logic        v16 = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        ov16, co16, of16;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .c_in(c1), .out_valid(ov1), .s(s1), .c_out(co1), .ovf(of1)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .c_in(c8), .out_valid(ov8), .s(s8), .c_out(co8), .ovf(of8)
  );
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16),
    .c_in(c16), .out_valid(ov16), .s(s16), .c_out(co16), .ovf(of16)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input int w, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    case (w)
      1: begin v1 = v; a1 = a[0]; b1 = b[0]; c1 = cin; end
      8: begin v8 = v; a8 = a[7:0]; b8 = b[7:0]; c8 = cin; end
      default: begin v16 = v; a16 = a; b16 = b; c16 = cin; end
    endcase
  endtask

  task automatic sample(input int w, output logic [15:0] s,
                        output logic co, output logic of, output logic vo);
    case (w)
      1: begin s = {15'd0, s1}; co = co1; of = of1; vo = ov1; end
      8: begin s = {8'd0, s8}; co = co8; of = of8; vo = ov8; end
      default: begin s = s16; co = co16; of = of16; vo = ov16; end
    endcase
  endtask

  // Reference: unsigned sum for s/c_out, signed range test for ovf.
  function automatic void model(input int w, input longint unsigned a,
                                input longint unsigned b, input bit cin,
                                output longint unsigned s, output bit co,
                                output bit ov);
    longint unsigned full;
    longint lim, sa, sb, ssum;
    full = a + b + longint'(cin);
    s    = full % (64'd1 << w);
    co   = (full >> w) != 0;
    lim  = longint'(1) << (w - 1);
    sa   = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
    sb   = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
    ssum = sa + sb + longint'(cin);
    ov   = (ssum >= lim) || (ssum < -lim);
  endfunction

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] gs;
    logic        gco, gof, gvo;
    longint unsigned es;
    bit          eco, eov;

    tbl.push_back('{1, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0});
    tbl.push_back('{1, 16'h0, 16'h0, 1'b1, 16'h1, 1'b0, 1'b1});
    tbl.push_back('{1, 16'h0, 16'h1, 1'b0, 16'h1, 1'b0, 1'b0});
    tbl.push_back('{1, 16'h0, 16'h1, 1'b1, 16'h0, 1'b1, 1'b0});
    tbl.push_back('{1, 16'h1, 16'h0, 1'b0, 16'h1, 1'b0, 1'b0});
    tbl.push_back('{1, 16'h1, 16'h0, 1'b1, 16'h0, 1'b1, 1'b0});
    tbl.push_back('{1, 16'h1, 16'h1, 1'b0, 16'h0, 1'b1, 1'b1});
    tbl.push_back('{1, 16'h1, 16'h1, 1'b1, 16'h1, 1'b1, 1'b0});
    tbl.push_back('{8, 16'hFF, 16'h00, 1'b1, 16'h00, 1'b1, 1'b0});
    tbl.push_back('{8, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1});
    tbl.push_back('{16, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0});
    tbl.push_back('{16, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{16, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1});

    // Reset state, with junk on the inputs.
    drive(16, 1'b1, 16'h1234, 16'h4321, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    foreach (tbl[k]) begin end
    for (int w = 1; w <= 16; w = (w == 1) ? 8 : 16 + (w == 16)) begin
      sample(w, gs, gco, gof, gvo);
      check($sformatf("reset_s_w%0d", w), gs, 0);
      check($sformatf("reset_co_w%0d", w), gco, 0);
      check($sformatf("reset_ovf_w%0d", w), gof, 0);
      check($sformatf("reset_vld_w%0d", w), gvo, 0);
    end
    rst_n = 1'b1;

    // Directed table: truth table and carry-chain boundaries.
    foreach (tbl[i]) begin
      drive(tbl[i].w, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
      @(posedge clk); #1;
      sample(tbl[i].w, gs, gco, gof, gvo);
      check($sformatf("tbl%0d_vld", i), gvo, 1);
      check($sformatf("tbl%0d_s", i), gs, tbl[i].s);
      check($sformatf("tbl%0d_co", i), gco, tbl[i].co);
      check($sformatf("tbl%0d_ovf", i), gof, tbl[i].ov);
    end

    // Hold: result stays put while in_valid is low, even with X inputs.
    drive(8, 1'b1, 16'd3, 16'd4, 1'b1);
    @(posedge clk); #1;
    check("hold_load_s", s8, 8);
    check("hold_load_vld", ov8, 1);
    drive(8, 1'b0, 16'hAA, 16'd4, 1'b1);
    @(posedge clk); #1;
    check("hold_vld", ov8, 0);
    check("hold_s", s8, 8);
    a8 = 'x; b8 = 'x; c8 = 1'bx;
    @(posedge clk); #1;
    check("hold_x_s", s8, 8);
    check("hold_x_co", co8, 0);
    check("hold_x_vld", ov8, 0);

    // Reset wins over a valid input in the same cycle.
    drive(1, 1'b1, 16'd1, 16'd1, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_s", s1, 0);
    check("rst_mid_co", co1, 0);
    check("rst_mid_ovf", of1, 0);
    check("rst_mid_vld", ov1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_after_s", s1, 1);
    check("rst_after_co", co1, 1);
    check("rst_after_vld", ov1, 1);

    // Back-to-back random stream at WIDTH=16.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 50 == 0) begin ra = 16'hFFFF; rb = 16'($urandom_range(0, 1)); end
      drive(16, 1'b1, ra, rb, rc);
      @(posedge clk); #1;
      model(16, ra, rb, rc, es, eco, eov);
      check($sformatf("rnd%0d_vld", i), ov16, 1);
      check($sformatf("rnd%0d_s", i), s16, es);
      check($sformatf("rnd%0d_co", i), co16, eco);
      check($sformatf("rnd%0d_ovf", i), of16, eov);
    end

    // Random W=1 and W=8 spot checks against the same model.
    for (int i = 0; i < 64; i++) begin
      int          w;
      logic [15:0] ra, rb;
      logic        rc;
      w  = (i % 2 == 0) ? 1 : 8;
      ra = 16'($urandom) & ((16'd1 << w) - 16'd1);
      rb = 16'($urandom) & ((16'd1 << w) - 16'd1);
      rc = 1'($urandom);
      drive(w, 1'b1, ra, rb, rc);
      @(posedge clk); #1;
      sample(w, gs, gco, gof, gvo);
      model(w, ra, rb, rc, es, eco, eov);
      check($sformatf("mix%0d_s", i), gs, es);
      check($sformatf("mix%0d_co", i), gco, eco);
      check($sformatf("mix%0d_ovf", i), gof, eov);
    end

    drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk); #1;
    check("end_vld", ov16, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Registered full adder: adds operands `a`, `b` and carry-in `c_in`, producing sum `s` and carry-out `c_out` one clock after the inputs are sampled. The default configuration is the classic 1-bit full adder. It serves as the arithmetic leaf cell for wider datapaths and as the reference cell for adder verification. Width is parameterised so the same block can be instantiated as a ripple-carry adder of any size.

## Interface
Parameters:
- `WIDTH`, default 1: operand and sum width in bits; legal range is 1 to 64.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  qualifies `a`, `b` and `c_in` for the current cycle.
- `a`  in  WIDTH  operand A, unsigned.
- `b`  in  WIDTH  operand B, unsigned.
- `c_in`  in  1  carry-in, added at weight 1.
- `out_valid`  out  1  `s`, `c_out` and `ovf` hold a new result.
- `s`  out  WIDTH  sum, equal to (a + b + c_in) mod 2^WIDTH.
- `c_out`  out  1  unsigned carry-out, bit WIDTH of the full sum.
- `ovf`  out  1  two's-complement overflow; equals carry into the MSB XOR carry out of the MSB.

## Operation
Per-bit cell function:
- sᵢ = aᵢ ^ bᵢ ^ cᵢ.
- cᵢ₊₁ = aᵢbᵢ | aᵢcᵢ | bᵢcᵢ.
- c₀ = `c_in`.

Carry chain:
- Ripple carry through WIDTH cells, computed combinationally within one cycle.
- `c_out` = c_WIDTH.
- `ovf` = c_WIDTH ^ c_(WIDTH-1).
- For WIDTH = 1, `ovf` = `c_out` ^ `c_in`.

Output update:
- When `in_valid` = 1 on a rising edge, `s`, `c_out` and `ovf` load the new result and `out_valid` goes to 1.
- When `in_valid` = 0 on a rising edge, `s`, `c_out` and `ovf` hold their previous values and `out_valid` goes to 0.

Width and data rules:
- The adder has no internal state other than the output registers.
- Inputs are never stalled; there is no backpressure.
- X or Z on inputs while `in_valid` = 0 must not disturb the outputs.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear at the outputs after edge N, stable through edge N+1.
- Throughput is 1 result per cycle; back-to-back `in_valid` is fully supported.
- Reset: when `rst_n` = 0 at a rising edge, the outputs after that edge are `s` = 0, `c_out` = 0, `ovf` = 0 and `out_valid` = 0.
- Reset takes priority over `in_valid`. Any transaction sampled in the same cycle as reset is discarded.
- Reset asserted mid-stream flushes the pending result. The first valid input after `rst_n` returns to 1 produces a result one cycle later, as normal.
- No asynchronous paths from input to output; all outputs come directly from registers.

## Structure
- Sub-module `fa_cell`: a combinational 1-bit full adder with ports `a`, `b`, `c_in`, `s`, `c_out`. The top instantiates WIDTH copies of it in a generate loop.
- The top holds only the carry-chain wiring, the `ovf` derivation and the output register bank.
- Shared package `full_adder_pkg` contains:
  - `FA_MAX_WIDTH` = 64, checked by an elaboration-time assertion on `WIDTH`.
  - A reference function `fa_ref(a, b, c_in)` returning the packed {`ovf`, `c_out`, `s`}, for use by the bench scoreboard.

## Test plan
1. WIDTH=1, exhaustive truth table: drive the 8 {a,b,c_in} combinations 000 through 111 with `in_valid` = 1, one per cycle. Required {c_out,s} one cycle later: 00, 01, 01, 10, 01, 10, 10, 11.
2. WIDTH=8, carry propagation: a=0xFF, b=0x00, c_in=1 -> s=0x00, c_out=1, ovf=0. Then a=0x7F, b=0x01, c_in=0 -> s=0x80, c_out=0, ovf=1.
3. Hold behaviour: valid a=3, b=4, c_in=1 (WIDTH=8) -> s=8. Next cycle drop `in_valid` and set a=0xAA -> `out_valid`=0 and s stays 8.
4. Reset mid-stream: drive `rst_n`=0 in the same cycle as a valid a=1, b=1, c_in=1 (WIDTH=1) -> outputs all 0 and `out_valid`=0. Release reset, drive the same input -> s=1, c_out=1 one cycle later.
5. Back-to-back random stream: 1000 random WIDTH=16 vectors with `in_valid` = 1 every cycle -> every output matches `fa_ref`, delayed exactly one cycle, with no gaps in `out_valid`.
